// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - opcodes, ALU op and M funct3 encodings, FSM states for alu_exec_unit (ALU_M_EXT_EN adds BUSY)
package alu_exec_unit_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // funct7 values accepted on OP
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // M-extension funct3 codes
  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_M_EXT_EN
    ST_BUSY = 2'd1,
`endif
    ST_DONE = 2'd2
  } state_e;

  // Opcodes whose operand A is the instruction address
  function automatic logic is_pc_rel(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_BRANCH) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiply / restoring divide, one bit per cycle (used under ALU_M_EXT_EN)
module alu_muldiv_iter
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic              busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              dz_q, dz_d;

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   quo, rem;

  // Operand magnitudes and result sign captured on start
  always_comb begin
    sgn_a = a[XLEN-1] & ((funct3 == M_MUL) || (funct3 == M_MULH) || (funct3 == M_MULHSU) ||
                         (funct3 == M_DIV) || (funct3 == M_REM));
    sgn_b = b[XLEN-1] & ((funct3 == M_MUL) || (funct3 == M_MULH) ||
                         (funct3 == M_DIV) || (funct3 == M_REM));
    mag_a = sgn_a ? -a : a;
    mag_b = sgn_b ? -b : b;
  end

  // One multiply or divide step on the accumulator; the low half carries the multiplier / quotient bits
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opb_q};
    div_ge   = ~div_diff[XLEN];
    if (f3_q[2]) begin
      acc_next = {(div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction and divide special cases applied to the final step's value
  always_comb begin
    prod = neg_q ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    case (f3_q)
      M_MUL:           result = prod[XLEN-1:0];
      M_DIV, M_DIVU:   result = dz_q ? '1 : (neg_q ? -quo : quo);
      M_REM, M_REMU:   result = dz_q ? a_q : (neg_q ? -rem : rem);
      default:         result = prod[2*XLEN-1:XLEN];
    endcase
  end

  assign done = busy_q && (cnt_q == CW'(XLEN - 1));

  // Load on start, then step the counter and accumulator while busy
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opb_d  = opb_q;
    a_d    = a_q;
    f3_d   = f3_q;
    neg_d  = neg_q;
    dz_d   = dz_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      acc_d  = {{XLEN{1'b0}}, mag_a};
      opb_d  = mag_b;
      a_d    = a;
      f3_d   = funct3;
      neg_d  = (funct3 == M_REM) ? sgn_a : (sgn_a ^ sgn_b);
      dz_d   = (b == '0);
    end else if (busy_q) begin
      acc_d = acc_next;
      cnt_d = cnt_q + CW'(1);
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opb_q  <= '0;
      a_q    <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      a_q    <= a_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
      dz_q   <= dz_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - decode + ALU execute unit with valid/ready result; ALU_M_EXT_EN adds iterative mul/div
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  import alu_exec_unit_pkg::*;

  localparam int SW = (XLEN == 64) ? 6 : 5;
  localparam logic [11-SW:0] SRAI_HI = {2'b01, {(10 - SW){1'b0}}};

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [11-SW:0]  imm_hi;
  logic            unused_inst;
  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [SW-1:0]   shamt;
  alu_op_e         alu_op;
  logic            dec_illegal;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

`ifdef ALU_M_EXT_EN
  logic            is_m_op;
  logic            md_start, md_done;
  logic [XLEN-1:0] md_result;
`endif

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign funct7      = inst[31:25];
  assign imm_hi      = inst[31:20+SW];
  assign unused_inst = ^{inst[24:15], inst[11:7]};

  // Operand selection, ALU op decode and legality
  always_comb begin
    op_a        = is_pc_rel(opcode) ? pc : rs1_data;
    op_b        = (opcode == OPC_OP) ? rs2_data : imm;
    alu_op      = ALU_ADD;
    dec_illegal = 1'b0;
`ifdef ALU_M_EXT_EN
    is_m_op     = 1'b0;
`endif
    if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      case (funct3)
        3'b000:  alu_op = (opcode == OPC_OP && inst[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = inst[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
    if (opcode == OPC_OP) begin
      if (funct7 == F7_MEXT) begin
`ifdef ALU_M_EXT_EN
        is_m_op = 1'b1;
`else
        dec_illegal = 1'b1;
`endif
      end else if (funct7 != F7_BASE && funct7 != F7_ALT) begin
        dec_illegal = 1'b1;
      end
    end
    // Immediate shifts: the bits above shamt must be zero, except the SRAI marker
    if (opcode == OPC_OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101) && imm_hi != '0 &&
        !(funct3 == 3'b101 && imm_hi == SRAI_HI)) begin
      dec_illegal = 1'b1;
    end
  end

  // Single-cycle ALU
  always_comb begin
    shamt = op_b[SW-1:0];
    case (alu_op)
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = op_a + op_b;
    endcase
  end

`ifdef ALU_M_EXT_EN
  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .funct3 (funct3),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result)
  );
`endif

  // Control FSM: accept in IDLE, iterate in BUSY, hold the result in DONE
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef ALU_M_EXT_EN
    md_start  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_M_EXT_EN
          if (is_m_op) begin
            md_start  = 1'b1;
            state_d   = ST_BUSY;
            result_d  = '0;
            illegal_d = 1'b0;
          end else
`endif
          begin
            state_d   = ST_DONE;
            result_d  = dec_illegal ? '0 : alu_res;
            illegal_d = dec_illegal;
          end
        end
      end
`ifdef ALU_M_EXT_EN
      ST_BUSY: begin
        if (md_done) begin
          state_d   = ST_DONE;
          result_d  = md_result;
          illegal_d = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit (M tests when ALU_M_EXT_EN is defined)
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] i12, input logic [2:0] f3, input logic [6:0] opc);
    return {i12, 5'd1, f3, 5'd3, opc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge
  task automatic issue(input logic [31:0] i_inst, input logic [31:0] i_pc, input logic [31:0] i_a,
                       input logic [31:0] i_b, input logic [31:0] i_imm);
    inst = i_inst; pc = i_pc; rs1_data = i_a; rs2_data = i_b; imm = i_imm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    inst = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_rel_vld"}, out_valid, 1'b0);
  endtask

  task automatic run(input string tag, input logic [31:0] i_inst, input logic [31:0] i_pc,
                     input logic [31:0] i_a, input logic [31:0] i_b, input logic [31:0] i_imm,
                     input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
    int lat;
    issue(i_inst, i_pc, i_a, i_b, i_imm);
    wait_out(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_ill"}, illegal, exp_ill);
    release_out(tag);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inst = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 32'h0);
    chk("rst_illegal", illegal, 1'b0);

    run("add",   r_type(7'h00, 3'b000), 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 1'b0, 0);
    run("sub",   r_type(7'h20, 3'b000), 32'h0, 32'h5, 32'h7, 32'h0, 32'hFFFFFFFE, 1'b0, 0);
    run("slt",   r_type(7'h00, 3'b010), 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 1'b0, 0);
    run("sltu",  r_type(7'h00, 3'b011), 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0, 0);
    run("xor",   r_type(7'h00, 3'b100), 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0, 1'b0, 0);
    run("or",    r_type(7'h00, 3'b110), 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hFFF0FFF0, 1'b0, 0);
    run("and",   r_type(7'h00, 3'b111), 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1'b0, 0);
    run("sll33", r_type(7'h00, 3'b001), 32'h0, 32'h1, 32'd33, 32'h0, 32'h2, 1'b0, 0);
    run("srl",   r_type(7'h00, 3'b101), 32'h0, 32'h80000000, 32'd4, 32'h0, 32'h08000000, 1'b0, 0);
    run("slli",  i_type(12'h003, 3'b001, 7'b0010011), 32'h0, 32'h1, 32'h0, 32'h3, 32'h8, 1'b0, 0);
    run("addi_neg", i_type(12'hC00, 3'b000, 7'b0010011), 32'h0, 32'h1000, 32'h0, 32'hFFFFFC00, 32'h00000C00, 1'b0, 0);
    run("auipc", {20'h00002, 5'd3, 7'b0010111}, 32'h1000, 32'hDEAD0000, 32'h0, 32'h00002000, 32'h3000, 1'b0, 0);
    run("jal",   {20'h0, 5'd1, 7'b1101111}, 32'h100, 32'hDEAD0000, 32'h0, 32'h8, 32'h108, 1'b0, 0);
    run("lui",   {20'h12345, 5'd3, 7'b0110111}, 32'h0, 32'h0, 32'h0, 32'h12345000, 32'h12345000, 1'b0, 0);
    run("ill_f7",    r_type(7'h10, 3'b000), 32'h0, 32'h3, 32'h4, 32'h0, 32'h0, 1'b1, 0);
    run("ill_slli",  i_type(12'h401, 3'b001, 7'b0010011), 32'h0, 32'h3, 32'h0, 32'h401, 32'h0, 1'b1, 0);
    run("ill_srai5", i_type(12'h420, 3'b101, 7'b0010011), 32'h0, 32'h3, 32'h0, 32'h420, 32'h0, 1'b1, 0);
`ifndef ALU_M_EXT_EN
    run("ill_mext",  r_type(7'h01, 3'b000), 32'h0, 32'h3, 32'h4, 32'h0, 32'h0, 1'b1, 0);
`endif

    // SRAI held under backpressure
    issue(i_type(12'h404, 3'b101, 7'b0010011), 32'h0, 32'h80000000, 32'h0, 32'h404);
    wait_out(lat);
    chk("srai_lat", 64'(lat), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("srai_res_hold", result, 32'hF8000000);
      chk("srai_vld_hold", out_valid, 1'b1);
      chk("srai_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    release_out("srai");
    chk("srai_rel_in_ready", in_ready, 1'b1);

    // No accept in DONE even with out_ready high; pending request accepted on the following edge
    issue(r_type(7'h00, 3'b000), 32'h0, 32'h10, 32'h20, 32'h0);
    wait_out(lat);
    chk("done_first_res", result, 32'h30);
    inst = r_type(7'h00, 3'b100); rs1_data = 32'hFF; rs2_data = 32'h0F; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("done_noacc_vld", out_valid, 1'b0);
    chk("done_noacc_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_next_vld", out_valid, 1'b1);
    chk("done_next_res", result, 32'hF0);

    // Reset while holding a result
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_done_vld", out_valid, 1'b0);
    chk("rst_done_rdy", in_ready, 1'b1);
    chk("rst_done_res", result, 32'h0);

`ifdef ALU_M_EXT_EN
    run("div",     r_type(7'h01, 3'b100), 32'h0, 32'hFFFFFFF9, 32'h2, 32'h0, 32'hFFFFFFFD, 1'b0, XLEN);
    run("rem",     r_type(7'h01, 3'b110), 32'h0, 32'hFFFFFFF9, 32'h2, 32'h0, 32'hFFFFFFFF, 1'b0, XLEN);
    run("divu0",   r_type(7'h01, 3'b101), 32'h0, 32'h1234, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, XLEN);
    run("remu0",   r_type(7'h01, 3'b111), 32'h0, 32'h1234, 32'h0, 32'h0, 32'h1234, 1'b0, XLEN);
    run("div0s",   r_type(7'h01, 3'b100), 32'h0, 32'hFFFFFFF9, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, XLEN);
    run("div_ovf", r_type(7'h01, 3'b100), 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, XLEN);
    run("rem_ovf", r_type(7'h01, 3'b110), 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, XLEN);
    run("mulh",    r_type(7'h01, 3'b001), 32'h0, 32'hFFFFFFFE, 32'h3, 32'h0, 32'hFFFFFFFF, 1'b0, XLEN);
    run("mul",     r_type(7'h01, 3'b000), 32'h0, 32'hFFFFFFFE, 32'h3, 32'h0, 32'hFFFFFFFA, 1'b0, XLEN);
    run("mulhu",   r_type(7'h01, 3'b011), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 1'b0, XLEN);
    run("mulhsu",  r_type(7'h01, 3'b010), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b0, XLEN);

    // Reset in the middle of a divide
    issue(r_type(7'h01, 3'b100), 32'h0, 32'h64, 32'h7, 32'h0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("busy_in_ready", in_ready, 1'b0);
    chk("busy_out_valid", out_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy_vld", out_valid, 1'b0);
    chk("rst_busy_rdy", in_ready, 1'b1);
    repeat (XLEN + 4) begin
      @(posedge clk); #1;
    end
    chk("rst_busy_no_result", out_valid, 1'b0);
    run("after_abort", r_type(7'h01, 3'b101), 32'h0, 32'h64, 32'h7, 32'h0, 32'h0000000E, 1'b0, XLEN);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
